// File: rtl/bsg_lru_pseudo_tree_ctrl.sv
// bsg_lru_pseudo_tree_ctrl
//   Per-set tree pseudo-LRU controller. Each of sets_p sets holds a (ways_p-1)-bit
//   PLRU tree. Touches (hit/fill) make a way MRU; queries return the LRU way one
//   cycle after acceptance. After reset, a sweep clears one set per cycle before
//   requests are accepted.
//
//   Ports:
//     clk_i, reset_n_i          clock, synchronous active-low reset
//     touch_v_i/set_i/way_i     touch request; touch_ready_o accepts
//     query_v_i/set_i           victim query; query_ready_o accepts
//     victim_v_o/victim_way_o   registered victim result, 1-cycle pulse
//     init_done_o               high once the clear sweep has finished
//
//   Build option: BSG_LRU_PSEUDO_TREE_CTRL_BYPASS_EN
//     defined   - a same-cycle same-set query sees the post-touch tree
//     undefined - the query sees the pre-touch tree (default)
module bsg_lru_pseudo_tree_ctrl #(
  parameter int ways_p = 8,
  parameter int sets_p = 64,
  localparam int lg_ways_lp = $clog2(ways_p),
  localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  touch_v_i,
  input  logic [lg_sets_lp-1:0] touch_set_i,
  input  logic [lg_ways_lp-1:0] touch_way_i,
  output logic                  touch_ready_o,
  input  logic                  query_v_i,
  input  logic [lg_sets_lp-1:0] query_set_i,
  output logic                  query_ready_o,
  output logic                  victim_v_o,
  output logic [lg_ways_lp-1:0] victim_way_o,
  output logic                  init_done_o
);

  localparam int tree_w_lp = ways_p - 1;

  typedef enum logic {INIT, READY} state_e;

  state_e                  state;
  logic [lg_sets_lp-1:0]   ptr;
  logic                    ready;
  logic [tree_w_lp-1:0]    tree [sets_p];

  logic                    touch_fire;
  logic                    query_fire;
  logic [tree_w_lp-1:0]    touch_cur;
  logic [tree_w_lp-1:0]    touch_mask;
  logic [tree_w_lp-1:0]    touch_data;
  logic [tree_w_lp-1:0]    touch_next;
  logic [tree_w_lp-1:0]    query_tree;
  logic [lg_ways_lp-1:0]   query_way;

  assign touch_fire    = touch_v_i & ready;
  assign query_fire    = query_v_i & ready;
  assign touch_ready_o = ready;
  assign query_ready_o = ready;
  assign init_done_o   = ready;

  // Touch decode: walk the path of touch_way_i, MSB at the root; each visited node
  // is pointed away from the touched way.
  always_comb begin
    logic [lg_ways_lp-1:0] w;
    logic [lg_ways_lp-1:0] node;
    logic                  b;
    touch_cur  = tree[touch_set_i];
    touch_mask = '0;
    touch_data = '0;
    w          = touch_way_i;
    node       = '0;
    for (int unsigned l = 0; l < lg_ways_lp; l++) begin
      b                = w[lg_ways_lp-1];
      touch_mask[node] = 1'b1;
      touch_data[node] = ~b;
      node             = lg_ways_lp'(32'(node) * 2 + 1 + 32'(b));
      w                = w << 1;
    end
    touch_next = (touch_cur & ~touch_mask) | (touch_data & touch_mask);
  end

`ifdef BSG_LRU_PSEUDO_TREE_CTRL_BYPASS_EN
  assign query_tree = (touch_fire && (touch_set_i == query_set_i))
                      ? touch_next : tree[query_set_i];
`else
  assign query_tree = tree[query_set_i];
`endif

  // Victim walk: follow the bit stored at each node, collecting way bits MSB first.
  always_comb begin
    logic [lg_ways_lp-1:0] node;
    logic                  b;
    query_way = '0;
    node      = '0;
    for (int unsigned l = 0; l < lg_ways_lp; l++) begin
      b         = query_tree[node];
      query_way = lg_ways_lp'({query_way, b});
      node      = lg_ways_lp'(32'(node) * 2 + 1 + 32'(b));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state        <= INIT;
      ptr          <= '0;
      ready        <= 1'b0;
      victim_v_o   <= 1'b0;
      victim_way_o <= '0;
    end else begin
      case (state)
        INIT: begin
          victim_v_o <= 1'b0;
          ptr        <= ptr + 1'b1;
          if (ptr == lg_sets_lp'(sets_p - 1)) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          victim_v_o <= query_fire;
          if (query_fire) victim_way_o <= query_way;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Tree storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && (state == INIT)) begin
      tree[ptr] <= '0;
    end else if (reset_n_i && touch_fire) begin
      tree[touch_set_i] <= touch_next;
    end
  end

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_ctrl.sv
module tb_bsg_lru_pseudo_tree_ctrl;
  localparam int WAYS = 8;
  localparam int SETS = 64;
  localparam int LGW  = 3;
  localparam int LGS  = 6;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           touch_v;
  logic [LGS-1:0] touch_set;
  logic [LGW-1:0] touch_way;
  logic           touch_ready;
  logic           query_v;
  logic [LGS-1:0] query_set;
  logic           query_ready;
  logic           victim_v;
  logic [LGW-1:0] victim_way;
  logic           init_done;

  always #5 clk = ~clk;

  bsg_lru_pseudo_tree_ctrl #(.ways_p(WAYS), .sets_p(SETS)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .touch_v_i(touch_v), .touch_set_i(touch_set), .touch_way_i(touch_way),
    .touch_ready_o(touch_ready),
    .query_v_i(query_v), .query_set_i(query_set), .query_ready_o(query_ready),
    .victim_v_o(victim_v), .victim_way_o(victim_way), .init_done_o(init_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tree bits as an array per set; node n has children 2n+1 / 2n+2.
  bit mdl [SETS][WAYS-1];
  bit m_ready = 1'b0;
  int m_cnt   = 0;
  bit m_vv    = 1'b0;
  int m_way   = 0;
  bit started = 1'b0;

  function automatic int m_walk(int s);
    int node = 0;
    int w = 0;
    for (int l = 0; l < LGW; l++) begin
      int b = int'(mdl[s][node]);
      w = w * 2 + b;
      node = 2 * node + 1 + b;
    end
    return w;
  endfunction

  function automatic void m_touch(int s, int way);
    int node = 0;
    for (int l = 0; l < LGW; l++) begin
      int b = (way >> (LGW - 1 - l)) & 1;
      mdl[s][node] = (b == 0);
      node = 2 * node + 1 + b;
    end
  endfunction

  initial begin
    int qw;
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!reset_n) begin
        m_ready = 1'b0; m_cnt = 0; m_vv = 1'b0; m_way = 0;
        for (int s = 0; s < SETS; s++)
          for (int n = 0; n < WAYS - 1; n++) mdl[s][n] = 1'b0;
      end else if (!m_ready) begin
        m_vv = 1'b0;
        m_cnt++;
        if (m_cnt == SETS) m_ready = 1'b1;
      end else begin
        if (touch_v) assert (int'(touch_set) < SETS);
        if (query_v) assert (int'(query_set) < SETS);
        qw = 0;
`ifdef BSG_LRU_PSEUDO_TREE_CTRL_BYPASS_EN
        if (touch_v) m_touch(int'(touch_set), int'(touch_way));
        if (query_v) qw = m_walk(int'(query_set));
`else
        if (query_v) qw = m_walk(int'(query_set));
        if (touch_v) m_touch(int'(touch_set), int'(touch_way));
`endif
        m_vv = query_v;
        if (query_v) m_way = qw;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("touch_ready", 32'(touch_ready), 32'(m_ready));
        check("query_ready", 32'(query_ready), 32'(m_ready));
        check("init_done",   32'(init_done),   32'(m_ready));
        check("victim_v",    32'(victim_v),    32'(m_vv));
        check("victim_way",  32'(victim_way),  32'(m_way));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_touch(int s, int w);
    touch_v = 1'b1; touch_set = LGS'(s); touch_way = LGW'(w);
    cyc();
    touch_v = 1'b0;
  endtask

  task automatic do_query(int s, int exp, string name);
    query_v = 1'b1; query_set = LGS'(s);
    cyc();
    query_v = 1'b0;
    check({name, "_v"}, 32'(victim_v), 32'd1);
    check(name, 32'(victim_way), 32'(exp));
  endtask

  task automatic wait_init(string name);
    int n = 0;
    check({name, "_start_low"}, 32'(touch_ready), 32'd0);
    while (!touch_ready && n < 200) begin
      cyc();
      n++;
    end
    check({name, "_cycles"}, 32'(n), 32'd64);
  endtask

  initial begin
    reset_n = 1'b0; touch_v = 1'b0; touch_set = '0; touch_way = '0;
    query_v = 1'b0; query_set = '0;
    cyc(); cyc();
    reset_n = 1'b1;

    // 1: sweep length; touch during INIT is dropped
    touch_v = 1'b1; touch_set = '0; touch_way = 3'd7;
    wait_init("init1");
    touch_v = 1'b0;
    do_query(0, 0, "init_touch_ignored");

    // 2: fresh set
    do_query(5, 0, "fresh_set5");
    cyc();
    check("victim_v_pulse", 32'(victim_v), 32'd0);
    check("victim_way_hold", 32'(victim_way), 32'd0);

    // 3: touch sequence
    do_touch(5, 0);
    do_query(5, 4, "set5_after_way0");
    do_touch(5, 4);
    do_query(5, 2, "set5_after_way4");

    // 4: same-set collision on a fresh set
    touch_v = 1'b1; touch_set = 6'd20; touch_way = 3'd0;
    query_v = 1'b1; query_set = 6'd20;
    cyc();
    touch_v = 1'b0; query_v = 1'b0;
`ifdef BSG_LRU_PSEUDO_TREE_CTRL_BYPASS_EN
    check("same_set_collision", 32'(victim_way), 32'd4);
`else
    check("same_set_collision", 32'(victim_way), 32'd0);
`endif
    do_query(20, 4, "collision_touch_committed");

    // 5: different-set concurrency
    touch_v = 1'b1; touch_set = 6'd7; touch_way = 3'd3;
    query_v = 1'b1; query_set = 6'd9;
    cyc();
    touch_v = 1'b0; query_v = 1'b0;
    check("diff_set_query", 32'(victim_way), 32'd0);
    do_query(7, 4, "set7_after_way3");

    // Mixed traffic: touches and back-to-back queries every cycle
    for (int i = 0; i < 64; i++) begin
      touch_v = 1'b1; touch_set = LGS'(i); touch_way = LGW'((i * 5) % 8);
      query_v = 1'b1; query_set = LGS'((i * 7 + 3) % 64);
      cyc();
    end
    touch_v = 1'b0;
    for (int i = 0; i < 16; i++) begin
      query_set = LGS'(i * 4);
      cyc();
      check("pipelined_v", 32'(victim_v), 32'd1);
    end
    query_v = 1'b0;
    cyc();

    // 6: reset lands on the query's acceptance edge
    query_v = 1'b1; query_set = 6'd5;
    reset_n = 1'b0;
    cyc();
    query_v = 1'b0;
    check("reset_abort_v", 32'(victim_v), 32'd0);
    check("reset_abort_way", 32'(victim_way), 32'd0);
    cyc();
    reset_n = 1'b1;
    wait_init("init2");
    do_query(5, 0, "set5_after_reset");
    do_query(20, 0, "set20_after_reset");
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
